// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit stage: FSM state encoding,
// line levels and frame geometry.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t RD     = 3'd1;
  localparam state_t LATCH  = 3'd2;
  localparam state_t START  = 3'd3;
  localparam state_t DATA   = 3'd4;
  localparam state_t PARITY = 3'd5;
  localparam state_t STOP   = 3'd6;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each
// bit with tick. clr holds the count at zero while no frame is on the line.
module uart_baud_gen #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// Drains a non-showahead byte FIFO one read per frame and serialises each byte
// as 8N1, or 8E1 when PARITY_EN is defined. All outputs decode from registers.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_q,
  output logic                 fifo_rdreq,
  output logic                 txd,
  output logic                 busy,
  output logic                 byte_done
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;

  if (BAUD_DIV < 2) begin : g_div_check
    $error("uart_fifo_tx: CLK_FREQ/BAUD must be at least 2");
  end

  state_t               state_q;
  state_t               state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic                 tick;
  logic                 clr;
  logic                 last_bit;

`ifdef PARITY_EN
  logic parity_q;
  logic parity_d;
`endif

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .tick    (tick)
  );

  assign last_bit = tick && (idx_q == IDX_W'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = RD;
      RD:    state_d = LATCH;
      LATCH: state_d = START;
      START: if (tick) state_d = DATA;
`ifdef PARITY_EN
      DATA:   if (last_bit) state_d = PARITY;
      PARITY: if (tick) state_d = STOP;
`else
      DATA:   if (last_bit) state_d = STOP;
`endif
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd        = IDLE_LEVEL;
    fifo_rdreq = 1'b0;
    busy       = 1'b1;
    byte_done  = 1'b0;
    clr        = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        clr  = 1'b1;
      end
      RD: begin
        fifo_rdreq = 1'b1;
        clr        = 1'b1;
      end
      LATCH: clr = 1'b1;
      START: txd = START_LEVEL;
      DATA:  txd = shift_q[0];
`ifdef PARITY_EN
      PARITY: txd = parity_q;
`endif
      STOP:  byte_done = tick;
      default: begin
        busy = 1'b0;
        clr  = 1'b1;
      end
    endcase
  end

  // The byte is captured once in LATCH and then shifted out LSB first.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (state_q == LATCH) begin
      shift_d = fifo_q;
      idx_d   = '0;
    end else if ((state_q == DATA) && tick) begin
      shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

`ifdef PARITY_EN
  // Parity is taken from the whole byte before shifting consumes it.
  always_comb begin
    parity_d = parity_q;
    if (state_q == LATCH) begin
      parity_d = even_parity(fifo_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a FIFO model feeds bytes, a line receiver decodes
// every frame and compares it with the bytes written, in write order.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_rdreq;
  logic       txd;
  logic       busy;
  logic       byte_done;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] mem [256];
  int wr_cnt = 0;
  int rd_cnt = 0;

  int fr_idx = 0;
  int frames_done = 0;
  int rdreq_n = 0;
  int start_cyc = 0;
  int last_rdreq_cyc = -100;
  int last_end_cyc = 0;
  int last_bd_cyc = 0;
  int bd_to_rd = -1;
  int glitch = 0;
  int busy_low = 0;
  int pos = 0;
  bit in_frame = 0;
  bit end_valid = 0;
  bit bd_valid = 0;
  bit busy_fall_pending = 0;
  bit chk_gap = 0;
  bit exp_bd = 0;
  logic bits [NB];

  uart_fifo_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .txd        (txd),
    .busy       (busy),
    .byte_done  (byte_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Normal-mode FIFO: data appears the cycle after the read request.
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      fifo_q <= mem[rd_cnt % 256];
      rd_cnt <= rd_cnt + 1;
    end
  end

  assign fifo_empty = (wr_cnt == rd_cnt);

  task automatic check(input string tag, input int obs, input int expd);
    n_chk++;
    if (obs != expd) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expd, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt % 256] = b;
    wr_cnt++;
    $display("push byte 0x%02h at cycle %0d", b, cyc);
  endtask

  task automatic idle_watch(input int n, input string tag);
    int viol;
    int r0;
    viol = 0;
    r0 = rdreq_n;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (txd !== 1'b1 || fifo_rdreq !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0) viol++;
    end
    check({tag, "_line_idle"}, viol, 0);
    check({tag, "_no_rdreq"}, rdreq_n - r0, 0);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && frames_done < target; i++) begin
      @(negedge clk);
    end
    #1;
    check({tag, "_frames"}, frames_done, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_pos(input int p, input int budget, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      #1;
      if (in_frame && (cyc - start_cyc) == p) found = 1;
    end
    check({tag, "_reached"}, int'(found), 1);
  endtask

  initial begin
    int r0;
    int f0;
    logic [7:0] b;

    // Line receiver: decodes frames from txd and checks framing and timing.
    fork
      forever begin
        @(negedge clk);
        if (!reset_n) begin
          if (in_frame) begin
            in_frame = 0;
            fr_idx++;
          end
          end_valid = 0;
          bd_valid = 0;
          busy_fall_pending = 0;
        end else begin
          if (busy_fall_pending) begin
            check("busy_fall", int'(busy), 0);
            busy_fall_pending = 0;
          end
          if (fifo_rdreq) begin
            rdreq_n++;
            check("rdreq_outside_frame", int'(in_frame), 0);
            check("rdreq_nonempty", int'(fifo_empty), 0);
            check("busy_at_rdreq", int'(busy), 1);
            if (bd_valid) bd_to_rd = cyc - last_bd_cyc;
            last_rdreq_cyc = cyc;
          end
          if (!in_frame && txd == 1'b0) begin
            in_frame = 1;
            start_cyc = cyc;
            glitch = 0;
            busy_low = 0;
            check("start_latency", cyc - last_rdreq_cyc, 2);
            if (chk_gap && end_valid) check("idle_gap", cyc - last_end_cyc - 1, 3);
          end
          exp_bd = 0;
          if (in_frame) begin
            pos = cyc - start_cyc;
            exp_bd = (pos == FRAME - 1);
            if (pos % DIV == 0) bits[pos / DIV] = txd;
            else if (txd != bits[pos / DIV]) glitch++;
            if (!busy) busy_low++;
          end
          if (byte_done || exp_bd) check("byte_done", int'(byte_done), int'(exp_bd));
          if (byte_done) begin
            last_bd_cyc = cyc;
            bd_valid = 1;
          end
          if (in_frame && exp_bd) begin
            logic [7:0] d;
            logic [7:0] e;
            for (int k = 0; k < 8; k++) d[k] = bits[k + 1];
            e = mem[fr_idx % 256];
            check("frame_expected", int'(fr_idx < wr_cnt), 1);
            check("data", int'(d), int'(e));
`ifdef PARITY_EN
            check("parity", int'(bits[9]), int'(^e));
`endif
            check("stop_bit", int'(bits[NB - 1]), 1);
            check("bit_hold", glitch, 0);
            check("busy_in_frame", busy_low, 0);
            $display("frame %0d: start %0d data 0x%02h expected 0x%02h", fr_idx, start_cyc, d, e);
            in_frame = 0;
            fr_idx++;
            frames_done++;
            last_end_cyc = cyc;
            end_valid = 1;
            busy_fall_pending = 1;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_txd", int'(txd), 1);
    check("reset_rdreq", int'(fifo_rdreq), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_byte_done", int'(byte_done), 0);
    reset_n = 1'b1;

    // Empty FIFO: line stays idle
    idle_watch(1000, "idle_empty");

    // Single byte 0x55
    @(negedge clk);
    #1;
    r0 = rdreq_n;
    f0 = frames_done;
    push(8'h55);
    wait_frames(f0 + 1, FRAME + 50, "byte55");
    idle_watch(50, "after55");
    check("rdreq_count55", rdreq_n - r0, 1);

    // Record 0x31 0x0D 0x0A preloaded, back-to-back frames
    do_reset();
    chk_gap = 1;
    @(negedge clk);
    #1;
    r0 = rdreq_n;
    f0 = frames_done;
    push(8'h31);
    push(8'h0D);
    push(8'h0A);
    wait_frames(f0 + 3, 3 * (FRAME + 10) + 50, "record");
    idle_watch(30, "after_record");
    check("rdreq_count_record", rdreq_n - r0, 3);

    // Parity-sensitive pair 0x07 (odd ones) and 0x03 (even ones)
    do_reset();
    @(negedge clk);
    #1;
    r0 = rdreq_n;
    f0 = frames_done;
    push(8'h07);
    push(8'h03);
    wait_frames(f0 + 2, 2 * (FRAME + 10) + 50, "parity_pair");
    check("rdreq_count_pair", rdreq_n - r0, 2);
    chk_gap = 0;

    // Random bytes written at random moments, some while a frame is running
    do_reset();
    r0 = rdreq_n;
    f0 = frames_done;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 150)) @(negedge clk);
      #1;
      push(8'($urandom_range(0, 255)));
    end
    wait_frames(f0 + 8, 8 * (FRAME + 10) + 100, "random");
    idle_watch(20, "after_random");
    check("rdreq_count_random", rdreq_n - r0, 8);
    check("fifo_drained", rd_cnt, wr_cnt);

    // Reset during data bit 3 of 0xA5: frame dropped, no re-read
    do_reset();
    @(negedge clk);
    #1;
    r0 = rdreq_n;
    b = 8'hA5;
    push(b);
    wait_pos(4 * DIV + 3, FRAME + 50, "bit3");
    #1;
    check("txd_bit3_before_reset", int'(txd), int'(b[3]));
    reset_n = 1'b0;
    #1;
    check("txd_async_reset", int'(txd), 1);
    check("busy_async_reset", int'(busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle_watch(200, "after_abort");
    check("rdreq_count_abort", rdreq_n - r0, 1);

    // New byte written while the previous frame is in its stop bit
    do_reset();
    chk_gap = 1;
    @(negedge clk);
    #1;
    r0 = rdreq_n;
    f0 = frames_done;
    push(8'($urandom_range(0, 255)));
    wait_pos((NB - 1) * DIV + 2, FRAME + 50, "stop_bit");
    #1;
    push(8'($urandom_range(0, 255)));
    wait_frames(f0 + 2, 2 * (FRAME + 10) + 50, "stop_write");
    check("bd_to_rdreq", bd_to_rd, 2);
    check("rdreq_count_stop", rdreq_n - r0, 2);
    chk_gap = 0;

    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
